// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int GEN_W  = 16;
    localparam int NSUM_W = 4;
    localparam logic [GEN_W-1:0] GEN_MAX = {GEN_W{1'b1}};

    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] value);
        return (value == GEN_MAX) ? value : value + GEN_W'(1);
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational B3/S23 next-state for one board row, given the rows above and below.
module life_row_next
    import life_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [0:WIDTH-1] above,
    input  logic [0:WIDTH-1] cur,
    input  logic [0:WIDTH-1] below,
    input  logic             wrap,
    output logic [0:WIDTH-1] next_row
);

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        localparam int L = (c == 0) ? WIDTH - 1 : c - 1;
        localparam int R = (c == WIDTH - 1) ? 0 : c + 1;

        logic              use_l;
        logic              use_r;
        logic [NSUM_W-1:0] sum;

        // Edge columns only see the opposite side of the row when wrapping.
        assign use_l = (c != 0) || wrap;
        assign use_r = (c != WIDTH - 1) || wrap;

        assign sum = NSUM_W'(above[L] & use_l) + NSUM_W'(above[c]) + NSUM_W'(above[R] & use_r)
                   + NSUM_W'(cur[L]   & use_l)                      + NSUM_W'(cur[R]   & use_r)
                   + NSUM_W'(below[L] & use_l) + NSUM_W'(below[c]) + NSUM_W'(below[R] & use_r);

        assign next_row[c] = (sum == NSUM_W'(3)) || (cur[c] && (sum == NSUM_W'(2)));
    end

endmodule

// File: rtl/life_engine.sv
// Row-serial Game of Life engine: row loads, single-step / free-run generations,
// with generation count plus stable and extinct status.
module life_engine
    import life_pkg::*;
#(
    parameter int HEIGHT   = 20,
    parameter int WIDTH    = 20,
    parameter int PERIOD_W = 26
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [$clog2(HEIGHT)-1:0]        load_row,
    input  logic [0:WIDTH-1]                 load_data,
    input  logic                             step,
    input  logic                             run_en,
    input  logic [PERIOD_W-1:0]              period,
    input  logic                             wrap,
    output logic [0:HEIGHT-1][0:WIDTH-1]     board,
    output logic                             busy,
    output logic                             gen_done,
    output logic [GEN_W-1:0]                 gen_count,
    output logic                             stable,
    output logic                             extinct
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    state_t                       state;
    logic [0:HEIGHT-1][0:WIDTH-1] board_q;
    logic [0:HEIGHT-1][0:WIDTH-1] shadow;
    logic [ROW_W-1:0]             row_idx;
    logic                         wrap_q;
    logic [PERIOD_W-1:0]          period_cnt;
    logic [GEN_W-1:0]             gen_cnt;

    logic                         load_fire;
    logic                         row_ok;
    logic                         start;
    logic [0:WIDTH-1]             above;
    logic [0:WIDTH-1]             below;
    logic [0:WIDTH-1]             next_row;

    assign load_ready = (state == IDLE) && !clear;
    assign load_fire  = load_valid && load_ready;
    assign row_ok     = {1'b0, load_row} < (ROW_W + 1)'(HEIGHT);
    // A load wins over a start request in the same cycle; the start is simply dropped.
    assign start      = (state == IDLE) && !clear && !load_fire
                        && (step || (run_en && (period_cnt == period)));

    assign board     = board_q;
    assign busy      = (state != IDLE);
    assign gen_count = gen_cnt;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        above = '0;
        below = '0;
        if (row_idx == '0) begin
            if (wrap_q) above = board_q[HEIGHT-1];
        end else begin
            above = board_q[row_idx - ROW_W'(1)];
        end
        if (row_idx == LAST_ROW) begin
            if (wrap_q) below = board_q[0];
        end else begin
            below = board_q[row_idx + ROW_W'(1)];
        end
    end

    life_row_next #(
        .WIDTH(WIDTH)
    ) u_row_next (
        .above    (above),
        .cur      (board_q[row_idx]),
        .below    (below),
        .wrap     (wrap_q),
        .next_row (next_row)
    );

    // NOTE: the shadow board is fully rewritten before every commit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == COMPUTE) shadow[row_idx] <= next_row;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            board_q    <= '0;
            row_idx    <= '0;
            wrap_q     <= 1'b0;
            period_cnt <= '0;
            gen_cnt    <= '0;
            gen_done   <= 1'b0;
            stable     <= 1'b0;
            extinct    <= 1'b1;
        end else begin
            gen_done <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                board_q    <= '0;
                row_idx    <= '0;
                period_cnt <= '0;
                gen_cnt    <= '0;
                stable     <= 1'b0;
                extinct    <= 1'b1;
            end else begin
                if (start || !run_en) begin
                    period_cnt <= '0;
                end else if (state == IDLE) begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                end

                case (state)
                    IDLE: begin
                        if (load_fire) begin
                            if (row_ok) begin
                                board_q[load_row] <= load_data;
                                stable            <= 1'b0;
                                extinct           <= 1'b0;
                            end
                        end else if (start) begin
                            state   <= COMPUTE;
                            row_idx <= '0;
                            wrap_q  <= wrap;
                        end
                    end
                    COMPUTE: begin
                        if (row_idx == LAST_ROW) begin
                            state <= COMMIT;
                        end else begin
                            row_idx <= row_idx + ROW_W'(1);
                        end
                    end
                    COMMIT: begin
                        board_q  <= shadow;
                        stable   <= (shadow == board_q);
                        extinct  <= (shadow == '0);
                        gen_cnt  <= sat_inc(gen_cnt);
                        gen_done <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench: a 5x5 dead-edge instance and an 8x8 toroidal instance share the clock and reset.
module tb_life_engine;

    localparam int AH = 5;
    localparam int AW = 5;
    localparam int BH = 8;
    localparam int BW = 8;
    localparam int PW = 26;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic                   a_clear, a_load_valid, a_load_ready, a_step, a_run_en, a_wrap;
    logic [2:0]             a_load_row;
    logic [0:AW-1]          a_load_data;
    logic [PW-1:0]          a_period;
    logic [0:AH-1][0:AW-1]  a_board;
    logic                   a_busy, a_gen_done, a_stable, a_extinct;
    logic [15:0]            a_gen_count;

    logic                   b_clear, b_load_valid, b_load_ready, b_step, b_run_en, b_wrap;
    logic [2:0]             b_load_row;
    logic [0:BW-1]          b_load_data;
    logic [PW-1:0]          b_period;
    logic [0:BH-1][0:BW-1]  b_board;
    logic                   b_busy, b_gen_done, b_stable, b_extinct;
    logic [15:0]            b_gen_count;

    life_engine #(.HEIGHT(AH), .WIDTH(AW), .PERIOD_W(PW)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .clear(a_clear),
        .load_valid(a_load_valid), .load_ready(a_load_ready),
        .load_row(a_load_row), .load_data(a_load_data),
        .step(a_step), .run_en(a_run_en), .period(a_period), .wrap(a_wrap),
        .board(a_board), .busy(a_busy), .gen_done(a_gen_done),
        .gen_count(a_gen_count), .stable(a_stable), .extinct(a_extinct)
    );

    life_engine #(.HEIGHT(BH), .WIDTH(BW), .PERIOD_W(PW)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .clear(b_clear),
        .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_row(b_load_row), .load_data(b_load_data),
        .step(b_step), .run_en(b_run_en), .period(b_period), .wrap(b_wrap),
        .board(b_board), .busy(b_busy), .gen_done(b_gen_done),
        .gen_count(b_gen_count), .stable(b_stable), .extinct(b_extinct)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All helpers start and end on a falling edge.
    task automatic a_load(input logic [2:0] r, input logic [0:AW-1] d);
        a_load_valid = 1'b1;
        a_load_row   = r;
        a_load_data  = d;
        @(negedge clk);
        a_load_valid = 1'b0;
    endtask

    task automatic b_load(input logic [2:0] r, input logic [0:BW-1] d);
        b_load_valid = 1'b1;
        b_load_row   = r;
        b_load_data  = d;
        @(negedge clk);
        b_load_valid = 1'b0;
    endtask

    task automatic a_clear_pulse();
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
    endtask

    task automatic a_step_gen(output int lat, output logic busy1);
        a_step = 1'b1;
        lat    = -1;
        busy1  = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            a_step = 1'b0;
            if (n == 1) busy1 = a_busy;
            if (a_gen_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic a_wait_done(output int n_out);
        n_out = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (a_gen_done) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic b_wait_done(output int n_out);
        n_out = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (b_gen_done) begin
                n_out = n;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:AH-1][0:AW-1] a_exp;
        logic [0:AH-1][0:AW-1] a_blink_h;
        logic [0:BH-1][0:BW-1] b_exp;
        logic [0:BH-1][0:BW-1] b_glider;
        int   lat, n, pulses, bad;
        logic busy1, seen_busy;

        reset_n = 1'b0;
        a_clear = 0; a_load_valid = 0; a_load_row = '0; a_load_data = '0;
        a_step = 0; a_run_en = 0; a_period = '0; a_wrap = 0;
        b_clear = 0; b_load_valid = 0; b_load_row = '0; b_load_data = '0;
        b_step = 0; b_run_en = 0; b_period = '0; b_wrap = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_board",      64'(a_board), 64'(0));
        check("rst_gen_count",  64'(a_gen_count), 64'(0));
        check("rst_busy",       64'(a_busy), 64'(0));
        check("rst_gen_done",   64'(a_gen_done), 64'(0));
        check("rst_stable",     64'(a_stable), 64'(0));
        check("rst_extinct",    64'(a_extinct), 64'(1));
        check("rst_load_ready", 64'(a_load_ready), 64'(1));
        check("rst_b_board",    64'(b_board), 64'(0));

        // Horizontal blinker, dead edges.
        a_blink_h    = '0;
        a_blink_h[2] = 5'b01110;
        a_load(3'd2, 5'b01110);
        check("load_visible", 64'(a_board), 64'(a_blink_h));
        check("load_extinct", 64'(a_extinct), 64'(0));

        a_step_gen(lat, busy1);
        a_exp    = '0;
        a_exp[1] = 5'b00100;
        a_exp[2] = 5'b00100;
        a_exp[3] = 5'b00100;
        check("blink1_latency", 64'(lat), 64'(7));
        check("blink1_busy_c1", 64'(busy1), 64'(1));
        check("blink1_busy_done", 64'(a_busy), 64'(0));
        check("blink1_board", 64'(a_board), 64'(a_exp));
        check("blink1_count", 64'(a_gen_count), 64'(1));
        check("blink1_stable", 64'(a_stable), 64'(0));

        a_step_gen(lat, busy1);
        check("blink2_latency", 64'(lat), 64'(7));
        check("blink2_board", 64'(a_board), 64'(a_blink_h));
        check("blink2_count", 64'(a_gen_count), 64'(2));

        // Block still life.
        a_clear_pulse();
        check("clr_board", 64'(a_board), 64'(0));
        check("clr_count", 64'(a_gen_count), 64'(0));
        check("clr_extinct", 64'(a_extinct), 64'(1));
        a_load(3'd1, 5'b01100);
        a_load(3'd2, 5'b01100);
        a_exp    = '0;
        a_exp[1] = 5'b01100;
        a_exp[2] = 5'b01100;
        a_step_gen(lat, busy1);
        check("block_board", 64'(a_board), 64'(a_exp));
        check("block_stable", 64'(a_stable), 64'(1));
        check("block_extinct", 64'(a_extinct), 64'(0));
        check("block_count", 64'(a_gen_count), 64'(1));

        // Lone cell dies.
        a_clear_pulse();
        a_load(3'd2, 5'b00100);
        a_step_gen(lat, busy1);
        check("lone_board", 64'(a_board), 64'(0));
        check("lone_extinct", 64'(a_extinct), 64'(1));
        check("lone_stable", 64'(a_stable), 64'(0));

        // Row index beyond the board is ignored.
        a_load(3'd6, 5'b11111);
        check("oob_load_board", 64'(a_board), 64'(0));

        // Free run, period 3: spacing HEIGHT+2+period.
        a_clear_pulse();
        a_load(3'd2, 5'b01110);
        a_period = PW'(3);
        a_run_en = 1'b1;
        a_wait_done(n);
        check("run_first_seen", 64'(n > 0), 64'(1));
        a_wait_done(n);
        check("run_spacing", 64'(n), 64'(10));
        check("run_count", 64'(a_gen_count), 64'(2));
        check("run_board", 64'(a_board), 64'(a_blink_h));
        a_run_en  = 1'b0;
        pulses    = 0;
        seen_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (a_gen_done) pulses++;
            if (a_busy) seen_busy = 1'b1;
        end
        check("run_stop_pulses", 64'(pulses), 64'(0));
        check("run_stop_busy", 64'(seen_busy), 64'(0));

        // Step and load together: row written, no generation.
        a_step       = 1'b1;
        a_load_valid = 1'b1;
        a_load_row   = 3'd0;
        a_load_data  = 5'b10000;
        @(negedge clk);
        a_step       = 1'b0;
        a_load_valid = 1'b0;
        check("stepload_row0", 64'(a_board[0]), 64'(5'b10000));
        check("stepload_busy", 64'(a_busy), 64'(0));
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_gen_done) pulses++;
        end
        check("stepload_pulses", 64'(pulses), 64'(0));
        check("stepload_count", 64'(a_gen_count), 64'(2));

        // Glider on an 8x8 torus returns home after 32 generations.
        b_glider    = '0;
        b_glider[0] = 8'b01000000;
        b_glider[1] = 8'b00100000;
        b_glider[2] = 8'b11100000;
        b_wrap = 1'b1;
        b_load(3'd0, b_glider[0]);
        b_load(3'd1, b_glider[1]);
        b_load(3'd2, b_glider[2]);
        b_period = '0;
        b_run_en = 1'b1;
        bad = 0;
        for (int g = 1; g <= 32; g++) begin
            b_wait_done(n);
            if (g == 32) b_run_en = 1'b0;
            if (g > 1 && n != 10) bad++;
            if (n < 0) bad++;
            if (g == 4) begin
                b_exp    = '0;
                b_exp[1] = 8'b00100000;
                b_exp[2] = 8'b00010000;
                b_exp[3] = 8'b01110000;
                check("glider_gen4", 64'(b_board), 64'(b_exp));
            end
        end
        check("glider_spacing_bad", 64'(bad), 64'(0));
        check("glider_home", 64'(b_board), 64'(b_glider));
        check("glider_count", 64'(b_gen_count), 64'(32));

        // Clear aborts a generation in flight.
        b_load(3'd7, 8'b10000001);
        b_load(3'd4, 8'b10100101);
        b_load(3'd5, 8'b00111100);
        b_step = 1'b1;
        @(negedge clk);
        b_step = 1'b0;
        check("abort_busy_c1", 64'(b_busy), 64'(1));
        @(negedge clk);
        b_load_valid = 1'b1;
        b_load_row   = 3'd7;
        b_load_data  = 8'hFF;
        check("abort_load_ready", 64'(b_load_ready), 64'(0));
        @(negedge clk);
        b_load_valid = 1'b0;
        check("abort_row7_kept", 64'(b_board[7]), 64'(8'b10000001));
        @(negedge clk);
        b_clear = 1'b1;
        @(negedge clk);
        b_clear = 1'b0;
        check("abort_busy", 64'(b_busy), 64'(0));
        check("abort_board", 64'(b_board), 64'(0));
        check("abort_count", 64'(b_gen_count), 64'(0));
        check("abort_done", 64'(b_gen_done), 64'(0));
        check("abort_extinct", 64'(b_extinct), 64'(1));
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (b_gen_done) pulses++;
        end
        check("abort_pulses", 64'(pulses), 64'(0));

        // Asynchronous reset mid-generation.
        a_step = 1'b1;
        @(negedge clk);
        a_step = 1'b0;
        @(negedge clk);
        check("arst_pre_busy", 64'(a_busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(a_busy), 64'(0));
        check("arst_board", 64'(a_board), 64'(0));
        check("arst_count", 64'(a_gen_count), 64'(0));
        check("arst_extinct", 64'(a_extinct), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
